// File: rtl/timer1_pkg.sv
// Shared constants for the Timer/Counter1 bus controller: I/O addresses,
// flag/mask bit positions and the CS1 clock-select encoding.
package timer1_pkg;

    localparam logic [5:0] ADDR_OCR1AL = 6'h2A;
    localparam logic [5:0] ADDR_OCR1AH = 6'h2B;
    localparam logic [5:0] ADDR_TCNT1L = 6'h2C;
    localparam logic [5:0] ADDR_TCNT1H = 6'h2D;
    localparam logic [5:0] ADDR_TCCR1B = 6'h2E;
    localparam logic [5:0] ADDR_TIFR   = 6'h38;
    localparam logic [5:0] ADDR_TIMSK  = 6'h39;

    localparam int TOV1_BIT   = 2;
    localparam int OCF1A_BIT  = 4;
    localparam int TOIE1_BIT  = 2;
    localparam int OCIE1A_BIT = 4;

    localparam logic [2:0] CS_STOP     = 3'd0;
    localparam logic [2:0] CS_DIV1     = 3'd1;
    localparam logic [2:0] CS_DIV8     = 3'd2;
    localparam logic [2:0] CS_DIV64    = 3'd3;
    localparam logic [2:0] CS_DIV256   = 3'd4;
    localparam logic [2:0] CS_DIV1024  = 3'd5;
    localparam logic [2:0] CS_EXT_FALL = 3'd6;
    localparam logic [2:0] CS_EXT_RISE = 3'd7;

    // Place the overflow-class and compare-class bits into a TIFR/TIMSK-shaped byte.
    function automatic logic [7:0] pack_flags(input logic ovf_bit, input logic cmp_bit);
        logic [7:0] r;
        r            = 8'h00;
        r[TOV1_BIT]  = ovf_bit;
        r[OCF1A_BIT] = cmp_bit;
        return r;
    endfunction

endpackage

// File: rtl/timer1_prescaler.sv
// Free-running prescaler, T1 pin synchronizer/edge detect and count-tick select.
module timer1_prescaler
    import timer1_pkg::*;
#(
    parameter int PRESC_WIDTH = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysClock,
    input  logic       reset,
    input  logic [2:0] cs,
    input  logic       t1_pin,
    output logic       tick
);

    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [SYNC_STAGES-1:0] t1_sync;
    logic                   t1_last;
    logic                   t1_rise;
    logic                   t1_fall;
    logic                   tick_next;

    assign t1_rise = t1_sync[SYNC_STAGES-1] & ~t1_last;
    assign t1_fall = ~t1_sync[SYNC_STAGES-1] & t1_last;

    // Choose the tick source for the current clock select.
    always_comb begin
        tick_next = 1'b0;
        case (cs)
            CS_STOP:     tick_next = 1'b0;
            CS_DIV1:     tick_next = 1'b1;
            CS_DIV8:     tick_next = &presc_cnt[2:0];
            CS_DIV64:    tick_next = &presc_cnt[5:0];
            CS_DIV256:   tick_next = &presc_cnt[7:0];
            CS_DIV1024:  tick_next = &presc_cnt[9:0];
            CS_EXT_FALL: tick_next = t1_fall;
            CS_EXT_RISE: tick_next = t1_rise;
        endcase
    end

    // Prescaler counts every cycle; the pin passes through the synchronizer, then the edge flop; tick is registered.
    always_ff @(posedge sysClock) begin
        if (!reset) begin
            presc_cnt <= '0;
            t1_sync   <= '0;
            t1_last   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
            t1_sync   <= {t1_sync[SYNC_STAGES-2:0], t1_pin};
            t1_last   <= t1_sync[SYNC_STAGES-1];
            tick      <= tick_next;
        end
    end

endmodule

// File: rtl/timer1_access_controller.sv
// CPU-side register block for Timer/Counter1: address decode, shared TEMP
// byte for atomic 16-bit access, TIFR flags and interrupt requests.
module timer1_access_controller
    import timer1_pkg::*;
#(
    parameter int PRESC_WIDTH = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sysClock,
    input  logic        reset,
    input  logic [5:0]  io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [7:0]  io_rdata,
    input  logic        t1_pin,
    input  logic [15:0] tcnt_value,
    input  logic        tov_event,
    input  logic        ocf_event,
    input  logic        irq_ovf_ack,
    input  logic        irq_cmp_ack,
    output logic        count_tick,
    output logic        tcnt_load_en,
    output logic [15:0] tcnt_load_value,
    output logic [15:0] ocr1a,
    output logic [7:0]  tifr,
    output logic        irq_ovf,
    output logic        irq_cmp
);

    logic [7:0] temp;
    logic [2:0] cs;
    logic       tov1;
    logic       ocf1a;
    logic       toie1;
    logic       ocie1a;
    logic       tick_raw;
    logic [7:0] rd_mux;

    logic we_tcnt_l, we_tcnt_h, we_ocr_l, we_ocr_h, we_tccr, we_tifr, we_timsk;
    logic re_tcnt_l;
    logic tov_clr, ocf_clr;

    assign we_tcnt_l = io_we && (io_addr == ADDR_TCNT1L);
    assign we_tcnt_h = io_we && (io_addr == ADDR_TCNT1H);
    assign we_ocr_l  = io_we && (io_addr == ADDR_OCR1AL);
    assign we_ocr_h  = io_we && (io_addr == ADDR_OCR1AH);
    assign we_tccr   = io_we && (io_addr == ADDR_TCCR1B);
    assign we_tifr   = io_we && (io_addr == ADDR_TIFR);
    assign we_timsk  = io_we && (io_addr == ADDR_TIMSK);
    assign re_tcnt_l = io_re && (io_addr == ADDR_TCNT1L);

    assign tov_clr = (we_tifr && io_wdata[TOV1_BIT]) || irq_ovf_ack;
    assign ocf_clr = (we_tifr && io_wdata[OCF1A_BIT]) || irq_cmp_ack;

    assign tifr       = pack_flags(tov1, ocf1a);
    assign irq_ovf    = tov1 & toie1;
    assign irq_cmp    = ocf1a & ocie1a;
    // The datapath must not count in the same cycle it is being preloaded.
    assign count_tick = tick_raw & ~tcnt_load_en;

    timer1_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_prescaler (
        .sysClock (sysClock),
        .reset    (reset),
        .cs       (cs),
        .t1_pin   (t1_pin),
        .tick     (tick_raw)
    );

    // Read mux works on current (pre-write) register state.
    always_comb begin
        rd_mux = 8'h00;
        case (io_addr)
            ADDR_TCNT1L: rd_mux = tcnt_value[7:0];
            ADDR_TCNT1H: rd_mux = temp;
            ADDR_OCR1AL: rd_mux = ocr1a[7:0];
            ADDR_OCR1AH: rd_mux = ocr1a[15:8];
            ADDR_TCCR1B: rd_mux = {5'b00000, cs};
            ADDR_TIFR:   rd_mux = tifr;
            ADDR_TIMSK:  rd_mux = pack_flags(toie1, ocie1a);
            default:     rd_mux = 8'h00;
        endcase
    end

    // TEMP, 16-bit register writes, preload strobe and clock select.
    always_ff @(posedge sysClock) begin
        if (!reset) begin
            temp            <= 8'h00;
            ocr1a           <= 16'h0000;
            cs              <= CS_STOP;
            tcnt_load_en    <= 1'b0;
            tcnt_load_value <= 16'h0000;
        end else begin
            tcnt_load_en <= we_tcnt_l;
            if (we_tcnt_l) tcnt_load_value <= {temp, io_wdata};
            if (we_ocr_l) ocr1a <= {temp, io_wdata};
            if (we_tccr) cs <= io_wdata[2:0];
            // A low-byte read latches the high byte after any TEMP use above.
            if (re_tcnt_l) temp <= tcnt_value[15:8];
            else if (we_tcnt_h || we_ocr_h) temp <= io_wdata;
        end
    end

    // Flags (set wins over clear), interrupt masks and registered read data.
    always_ff @(posedge sysClock) begin
        if (!reset) begin
            tov1     <= 1'b0;
            ocf1a    <= 1'b0;
            toie1    <= 1'b0;
            ocie1a   <= 1'b0;
            io_rdata <= 8'h00;
        end else begin
            tov1  <= tov_event | (tov1 & ~tov_clr);
            ocf1a <= ocf_event | (ocf1a & ~ocf_clr);
            if (we_timsk) begin
                toie1  <= io_wdata[TOIE1_BIT];
                ocie1a <= io_wdata[OCIE1A_BIT];
            end
            if (io_re) io_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_timer1_access_controller.sv
// Self-checking bench for timer1_access_controller: read data and preload
// strobes are predicted into queues and compared when the DUT produces them.
module tb_timer1_access_controller;
    import timer1_pkg::*;

    logic        sysClock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  io_addr = 6'h00;
    logic [7:0]  io_wdata = 8'h00;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [7:0]  io_rdata;
    logic        t1_pin = 1'b0;
    logic [15:0] tcnt_value = 16'h0000;
    logic        tov_event = 1'b0;
    logic        ocf_event = 1'b0;
    logic        irq_ovf_ack = 1'b0;
    logic        irq_cmp_ack = 1'b0;
    logic        count_tick;
    logic        tcnt_load_en;
    logic [15:0] tcnt_load_value;
    logic [15:0] ocr1a;
    logic [7:0]  tifr;
    logic        irq_ovf;
    logic        irq_cmp;

    timer1_access_controller #(.PRESC_WIDTH(10), .SYNC_STAGES(2)) dut (
        .sysClock        (sysClock),
        .reset           (reset),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_we           (io_we),
        .io_re           (io_re),
        .io_rdata        (io_rdata),
        .t1_pin          (t1_pin),
        .tcnt_value      (tcnt_value),
        .tov_event       (tov_event),
        .ocf_event       (ocf_event),
        .irq_ovf_ack     (irq_ovf_ack),
        .irq_cmp_ack     (irq_cmp_ack),
        .count_tick      (count_tick),
        .tcnt_load_en    (tcnt_load_en),
        .tcnt_load_value (tcnt_load_value),
        .ocr1a           (ocr1a),
        .tifr            (tifr),
        .irq_ovf         (irq_ovf),
        .irq_cmp         (irq_cmp)
    );

    always #5 sysClock = ~sysClock;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [15:0] load_q[$];
    rd_exp_t     rd_e;
    logic [15:0] load_e;
    logic        re_d = 1'b0;
    int          load_pulses = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge sysClock) re_d <= io_re;

    // Scoreboard side: compare read data and preload pulses against predictions.
    always @(negedge sysClock) begin
        if (re_d) begin
            check("rd_queued", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                rd_e = rd_q.pop_front();
                check(rd_e.tag, io_rdata, rd_e.exp);
            end
        end
        if (tcnt_load_en === 1'b1) begin
            load_pulses++;
            check("load_queued", 32'(load_q.size() != 0), 1);
            if (load_q.size() != 0) begin
                load_e = load_q.pop_front();
                check("load_value", tcnt_load_value, load_e);
            end
            check("tick_blocked_on_load", count_tick, 0);
        end
    end

    task automatic step();
        @(posedge sysClock);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        step();
        io_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
        rd_q.push_back('{tag, exp});
        io_addr = a; io_re = 1'b1;
        step();
        io_re = 1'b0;
    endtask

    // Drive one T1 pin level change on a falling clock edge and watch six cycles.
    task automatic ext_edge(input string tag, input logic lvl, input int exp_first);
        int first;
        int n;
        first = -1;
        n = 0;
        @(negedge sysClock);
        t1_pin = lvl;
        for (int k = 1; k <= 6; k++) begin
            @(negedge sysClock);
            if (count_tick) begin
                n++;
                if (first < 0) first = k;
            end
        end
        check({tag, "_delay"}, first, exp_first);
        check({tag, "_count"}, n, (exp_first < 0) ? 0 : 1);
    endtask

    task automatic count_ticks(input string tag, input int cycles, input int exp_n, input int exp_gap);
        int n;
        int last;
        n = 0;
        last = -1;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (count_tick) begin
                if (last >= 0) check({tag, "_spacing"}, i - last, exp_gap);
                last = i;
                n++;
            end
        end
        check({tag, "_count"}, n, exp_n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held with a TCCR1B write pending.
        reset = 1'b0; io_addr = ADDR_TCCR1B; io_wdata = 8'h01; io_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ctrl", {count_tick, tcnt_load_en, irq_ovf, irq_cmp}, 0);
            check("rst_regs", {ocr1a, tifr, io_rdata}, 0);
            check("rst_load_value", tcnt_load_value, 0);
        end
        io_we = 1'b0;
        reset = 1'b1;
        step();
        check("rst_no_tick", count_tick, 0);
        rd("rst_tccr1b", ADDR_TCCR1B, 8'h00);

        // Atomic preload with CS=1.
        wr(ADDR_TCCR1B, 8'h01);
        step();
        check("div1_tick", count_tick, 1);
        wr(ADDR_TCNT1H, 8'h12);
        load_q.push_back(16'h1234);
        wr(ADDR_TCNT1L, 8'h34);
        step();
        check("load_single", tcnt_load_en, 0);
        check("tick_after_load", count_tick, 1);

        // Atomic read through TEMP.
        tcnt_value = 16'hABCD;
        rd("rd_tcnt1l", ADDR_TCNT1L, 8'hCD);
        tcnt_value = 16'hFFFF;
        rd("rd_tcnt1h", ADDR_TCNT1H, 8'hAB);

        // Simultaneous write and read of TCNT1L: old TEMP for the load, new TEMP latched.
        wr(ADDR_TCNT1H, 8'h56);
        tcnt_value = 16'h9A3C;
        load_q.push_back(16'h5678);
        rd_q.push_back('{"rw_tcnt1l", 8'h3C});
        io_addr = ADDR_TCNT1L; io_wdata = 8'h78; io_we = 1'b1; io_re = 1'b1;
        step();
        io_we = 1'b0; io_re = 1'b0;
        rd("rw_tcnt1h", ADDR_TCNT1H, 8'h9A);

        // Simultaneous write and read of TCCR1B returns the old select; switch to /8.
        rd_q.push_back('{"rw_tccr1b", 8'h01});
        io_addr = ADDR_TCCR1B; io_wdata = 8'h02; io_we = 1'b1; io_re = 1'b1;
        step();
        io_we = 1'b0; io_re = 1'b0;
        repeat (8) step();
        count_ticks("div8", 64, 8, 8);
        wr(ADDR_TCCR1B, 8'h03);
        repeat (64) step();
        count_ticks("div64", 128, 2, 64);

        // External clock, rising then falling edge select.
        wr(ADDR_TCCR1B, 8'h07);
        repeat (6) step();
        for (int e = 0; e < 3; e++) begin
            ext_edge("ext_rise", 1'b1, 3);
            ext_edge("ext_rise_fall_ignored", 1'b0, -1);
        end
        wr(ADDR_TCCR1B, 8'h06);
        repeat (6) step();
        ext_edge("ext_fall_rise_ignored", 1'b1, -1);
        ext_edge("ext_fall", 1'b0, 3);
        wr(ADDR_TCCR1B, 8'h00);

        // Flags and interrupt requests.
        wr(ADDR_TIMSK, 8'h14);
        rd("rd_timsk", ADDR_TIMSK, 8'h14);
        ocf_event = 1'b1; step(); ocf_event = 1'b0;
        check("ocf_set", tifr, 8'h10);
        check("irq_cmp_set", irq_cmp, 1);
        check("irq_ovf_idle", irq_ovf, 0);
        io_addr = ADDR_TIFR; io_wdata = 8'h10; io_we = 1'b1; ocf_event = 1'b1;
        step();
        io_we = 1'b0; ocf_event = 1'b0;
        check("ocf_set_wins", tifr, 8'h10);
        check("irq_cmp_held", irq_cmp, 1);
        irq_cmp_ack = 1'b1; step(); irq_cmp_ack = 1'b0;
        check("ocf_ack_clear", tifr, 8'h00);
        check("irq_cmp_cleared", irq_cmp, 0);
        tov_event = 1'b1; step(); tov_event = 1'b0;
        check("tov_set", tifr, 8'h04);
        check("irq_ovf_set", irq_ovf, 1);
        wr(ADDR_TIFR, 8'h00);
        check("tifr_write0_noop", tifr, 8'h04);
        rd("rd_tifr", ADDR_TIFR, 8'h04);
        wr(ADDR_TIFR, 8'h04);
        check("tov_write1_clear", tifr, 8'h00);
        check("irq_ovf_cleared", irq_ovf, 0);
        tov_event = 1'b1; step(); tov_event = 1'b0;
        irq_ovf_ack = 1'b1; step(); irq_ovf_ack = 1'b0;
        check("tov_ack_clear", tifr, 8'h00);
        wr(ADDR_TIMSK, 8'h00);
        ocf_event = 1'b1; step(); ocf_event = 1'b0;
        check("ocf_masked_flag", tifr, 8'h10);
        check("irq_cmp_masked", irq_cmp, 0);
        irq_cmp_ack = 1'b1; step(); irq_cmp_ack = 1'b0;

        // OCR1A through TEMP.
        wr(ADDR_OCR1AH, 8'h00);
        wr(ADDR_OCR1AL, 8'h0A);
        check("ocr1a_write", ocr1a, 16'h000A);
        rd("rd_ocr1ah", ADDR_OCR1AH, 8'h00);
        rd("rd_ocr1al", ADDR_OCR1AL, 8'h0A);
        wr(ADDR_OCR1AH, 8'h55);
        check("ocr1a_high_only", ocr1a, 16'h000A);
        wr(ADDR_OCR1AL, 8'h66);
        check("ocr1a_second", ocr1a, 16'h5566);
        wr(6'h10, 8'hFF);
        check("unmapped_write", {ocr1a, tifr}, 32'h0055_6600);
        rd("rd_unmapped", 6'h10, 8'h00);

        // Reset in the middle of a write.
        wr(ADDR_TCCR1B, 8'h01);
        reset = 1'b0; io_addr = ADDR_OCR1AL; io_wdata = 8'h11; io_we = 1'b1;
        step();
        reset = 1'b1; io_we = 1'b0;
        check("midreset_ocr1a", ocr1a, 16'h0000);
        check("midreset_tick", count_tick, 0);
        step();
        check("midreset_stopped", count_tick, 0);
        rd("midreset_tccr1b", ADDR_TCCR1B, 8'h00);

        repeat (3) step();
        check("load_pulses", load_pulses, 2);
        check("rd_q_drained", rd_q.size(), 0);
        check("load_q_drained", load_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer1_access_controller.md
Name: timer1_access_controller

Overview:
- Bus-side controller for the 16-bit Timer/Counter1 datapath.
- Decodes CPU I/O accesses to TCNT1, OCR1A, TCCR1B, TIFR and TIMSK, and implements the AVR shared-TEMP protocol for atomic 16-bit access.
- Generates the prescaled count tick and the preload strobe that sequence the datapath.
- Owns the TIFR flag and interrupt-request logic; the datapath supplies only raw overflow and compare events.

Parameters:
- PRESC_WIDTH, 10, width of the free-running prescaler counter (covers /1024).
- SYNC_STAGES, 2, synchronizer depth for the external T1 pin.

Ports:
- sysClock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the sysClock rising edge.
- io_addr  in  6  I/O-space address.
- io_wdata  in  8  write data.
- io_we  in  1  write strobe, one cycle per access.
- io_re  in  1  read strobe, one cycle per access.
- io_rdata  out  8  read data, registered.
- t1_pin  in  1  asynchronous external clock pin.
- tcnt_value  in  16  current TCNT1 from the datapath.
- tov_event  in  1  one-cycle overflow pulse from the datapath.
- ocf_event  in  1  one-cycle compare-match pulse from the datapath.
- irq_ovf_ack  in  1  overflow vector taken; clears TOV1.
- irq_cmp_ack  in  1  compare vector taken; clears OCF1A.
- count_tick  out  1  one-cycle count enable to the datapath.
- tcnt_load_en  out  1  one-cycle preload strobe.
- tcnt_load_value  out  16  preload value.
- ocr1a  out  16  OCR1A register.
- tifr  out  8  TIFR register.
- irq_ovf  out  1  overflow interrupt request.
- irq_cmp  out  1  compare interrupt request.

Behaviour:
- Reset (reset==0 at a clock edge) clears every register and output to 0, including TEMP, the prescaler, the synchronizer and io_rdata. CS=0 means the timer is stopped, so no tick occurs. Reset dominates all other inputs, mid-access included.
- Address map: TCNT1H 0x2D, TCNT1L 0x2C, OCR1AH 0x2B, OCR1AL 0x2A, TCCR1B 0x2E (bits [2:0]=CS1, others read 0), TIFR 0x38, TIMSK 0x39. Unmapped addresses: writes ignored, reads return 0.
- Writes to TCNT1H or OCR1AH load TEMP only.
- Write to TCNT1L:
  - next cycle, tcnt_load_en=1 with tcnt_load_value={TEMP, io_wdata}, for exactly one cycle;
  - count_tick is forced to 0 in the same cycle as tcnt_load_en.
- Write to OCR1AL: ocr1a <= {TEMP, io_wdata}, visible the next cycle.
- Reads: io_rdata is valid the cycle after io_re and holds its value until the next io_re.
  - TCNT1L returns tcnt_value[7:0] and simultaneously latches tcnt_value[15:8] into TEMP.
  - TCNT1H returns TEMP.
  - OCR1AH and OCR1AL return the ocr1a bytes directly.
  - TIFR, TIMSK and TCCR1B return their register values.
- io_we and io_re in the same cycle (same address):
  - the read returns pre-write state;
  - a TCNT1L write uses the old TEMP, then TEMP takes the latched high byte.
- Prescaler:
  - PRESC_WIDTH counter increments every cycle; it is cleared only by reset.
  - count_tick per CS1: 0 → never; 1 → every cycle; 2/3/4/5 → when counter low 3/6/8/10 bits are all ones (/8, /64, /256, /1024).
  - CS1 6 or 7 → on a falling or rising edge of t1_pin, detected after the SYNC_STAGES synchronizer plus one edge-detect flop. A pin edge produces a tick 3 cycles later.
- A CS1 change takes effect the cycle after the write. The prescaler is not reset, so the first divided tick may come early.
- TIFR: bit2=TOV1, bit4=OCF1A; all other bits read 0.
  - Event pulse sets the flag.
  - Writing 1 to a bit, or the matching ack, clears it; writing 0 has no effect.
  - A set and a clear in the same cycle leave the flag at 1.
- TIMSK: bit2=TOIE1, bit4=OCIE1A.
- irq_ovf = TOV1 & TOIE1 and irq_cmp = OCF1A & OCIE1A, both registered from the flag and mask registers (no extra latency beyond them).

Decomposition:
- Package timer1_pkg holds:
  - the I/O address constants;
  - TIFR/TIMSK bit indices;
  - the CS1 encoding localparams (CS_STOP, CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024, CS_EXT_FALL, CS_EXT_RISE).
- One sub-module, timer1_prescaler: prescaler counter, T1 synchronizer and edge detect, tick select.
- The register/TEMP/flag logic stays in the top level.

Test Plan:
- Reset: hold reset=0 for 3 cycles with io_we=1 to TCCR1B data 0x01 → all outputs 0, no count_tick, TCCR1B reads 0x00.
- Atomic preload: write TCNT1H=0x12, then TCNT1L=0x34 → tcnt_load_en is a single pulse with tcnt_load_value=0x1234; count_tick=0 in that cycle with CS=1.
- Atomic read: tcnt_value=0xABCD, read TCNT1L → 0xCD; change tcnt_value to 0xFFFF, read TCNT1H → 0xAB.
- Prescale: CS=2 for 64 cycles → exactly 8 ticks, spaced 8 cycles apart. CS=7 with 3 rising t1_pin edges → 3 ticks, each 3 cycles after its edge.
- Flags: TIMSK=0x14, pulse ocf_event → irq_cmp=1. Write TIFR=0x10 in the same cycle as a new ocf_event → OCF1A stays 1. Then irq_cmp_ack alone → OCF1A=0, irq_cmp=0.
- OCR1A: write OCR1AH=0x00, OCR1AL=0x0A → ocr1a=0x000A, reads back 0x00/0x0A. Writing OCR1AH alone leaves ocr1a unchanged.
